// File: rtl/blake_state_writeback.sv
// BLAKE-512 working-state register file and G-step sequencer for the 1Gcore datapath.
// Holds v0..v15, writes each G result back to its column/diagonal words and flags completion.
module blake_state_writeback #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_valid,
  input  logic [1023:0] v_init,
  input  logic          abort,
  input  logic          g_valid,
  input  logic [63:0]   a_out,
  input  logic [63:0]   b_out,
  input  logic [63:0]   c_out,
  input  logic [63:0]   d_out,
  output logic [1023:0] v_out,
  output logic [6:0]    counter_idx,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [6:0] LAST_IDX = 7'(NUM_ROUNDS * 8 - 1);

  state_t      state;
  logic [63:0] v [16];
  logic [3:0]  idx_a, idx_b, idx_c, idx_d;

  // Word selection must match the operand selection in blake_state_mux exactly.
  always_comb begin
    // NOTE: default every combinational output first so no path through the case infers a latch.
    {idx_a, idx_b, idx_c, idx_d} = {4'd0, 4'd4, 4'd8, 4'd12};
    case (counter_idx[2:0])
      3'd0: {idx_a, idx_b, idx_c, idx_d} = {4'd0, 4'd4, 4'd8,  4'd12};
      3'd1: {idx_a, idx_b, idx_c, idx_d} = {4'd1, 4'd5, 4'd9,  4'd13};
      3'd2: {idx_a, idx_b, idx_c, idx_d} = {4'd2, 4'd6, 4'd10, 4'd14};
      3'd3: {idx_a, idx_b, idx_c, idx_d} = {4'd3, 4'd7, 4'd11, 4'd15};
      3'd4: {idx_a, idx_b, idx_c, idx_d} = {4'd0, 4'd5, 4'd10, 4'd15};
      3'd5: {idx_a, idx_b, idx_c, idx_d} = {4'd1, 4'd6, 4'd11, 4'd12};
      3'd6: {idx_a, idx_b, idx_c, idx_d} = {4'd2, 4'd7, 4'd8,  4'd13};
      3'd7: {idx_a, idx_b, idx_c, idx_d} = {4'd3, 4'd4, 4'd9,  4'd14};
      default: ;
    endcase
  end

  always_comb begin
    v_out = '0;
    for (int k = 0; k < 16; k++) begin
      v_out[1023 - 64 * k -: 64] = v[k];
    end
  end

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      counter_idx <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      // NOTE: the state words are individual flops, not a RAM, so they take the reset like any register.
      for (int k = 0; k < 16; k++) begin
        v[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (init_valid) begin
            for (int k = 0; k < 16; k++) begin
              v[k] <= v_init[1023 - 64 * k -: 64];
            end
            counter_idx <= '0;
            state       <= RUN;
            busy        <= 1'b1;
          end
        end
        RUN: begin
          // Abort wins over a G result arriving in the same cycle; v is left as-is.
          if (abort) begin
            state       <= IDLE;
            counter_idx <= '0;
            busy        <= 1'b0;
          end else if (g_valid) begin
            v[idx_a] <= a_out;
            v[idx_b] <= b_out;
            v[idx_c] <= c_out;
            v[idx_d] <= d_out;
            if (counter_idx == LAST_IDX) begin
              done        <= 1'b1;
              state       <= DONE;
              counter_idx <= '0;
              busy        <= 1'b0;
            end else begin
              counter_idx <= counter_idx + 7'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blake_state_writeback.sv
// Scoreboard bench for blake_state_writeback: a driver feeds a behavioural model and queues
// expectations, and per-DUT monitors compare each registered response one edge later.
module tb_blake_state_writeback;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          init_valid [2];
  logic [1023:0] v_init     [2];
  logic          abort      [2];
  logic          g_valid    [2];
  logic [63:0]   a_in [2], b_in [2], c_in [2], d_in [2];
  logic [1023:0] v_out      [2];
  logic [6:0]    counter_idx[2];
  logic          busy [2], done [2];

  blake_state_writeback #(.NUM_ROUNDS(16)) dut16 (
    .clk(clk), .rst(rst), .init_valid(init_valid[0]), .v_init(v_init[0]), .abort(abort[0]),
    .g_valid(g_valid[0]), .a_out(a_in[0]), .b_out(b_in[0]), .c_out(c_in[0]), .d_out(d_in[0]),
    .v_out(v_out[0]), .counter_idx(counter_idx[0]), .busy(busy[0]), .done(done[0])
  );

  blake_state_writeback #(.NUM_ROUNDS(1)) dut1 (
    .clk(clk), .rst(rst), .init_valid(init_valid[1]), .v_init(v_init[1]), .abort(abort[1]),
    .g_valid(g_valid[1]), .a_out(a_in[1]), .b_out(b_in[1]), .c_out(c_in[1]), .d_out(d_in[1]),
    .v_out(v_out[1]), .counter_idx(counter_idx[1]), .busy(busy[1]), .done(done[1])
  );

  typedef struct packed {
    logic [1023:0] v;
    logic [6:0]    idx;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays, a mode number and a step count.
  logic [63:0] mv [2][16];
  int mcnt [2];
  int mmode[2];          // 0 idle, 1 running, 2 finished
  int last_step[2] = '{127, 7};

  localparam logic [63:0] CST [16] = '{
    64'h243F6A8885A308D3, 64'h13198A2E03707344, 64'hA4093822299F31D0, 64'h082EFA98EC4E6C89,
    64'h452821E638D01377, 64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD, 64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B, 64'hD1310BA698DFB5AC, 64'h2FFD72DBD01ADFB7, 64'hB8E1AFED6A267E96,
    64'hBA7C9045F12C7F99, 64'h24A19947B3916CF7, 64'h0801F2E2858EFC16, 64'h636920D871574E69};
  localparam logic [63:0] IV [8] = '{
    64'h6A09E667F3BCC908, 64'hBB67AE8584CAA73B, 64'h3C6EF372FE94F82B, 64'hA54FF53A5F1D36F1,
    64'h510E527FADE682D1, 64'h9B05688C2B3E6C1F, 64'h1F83D9ABFB41BD6B, 64'h5BE0CD19137E2179};
  localparam int SIGMA [10][16] = '{
    '{ 0, 1, 2, 3, 4, 5, 6, 7, 8, 9,10,11,12,13,14,15},
    '{14,10, 4, 8, 9,15,13, 6, 1,12, 0, 2,11, 7, 5, 3},
    '{11, 8,12, 0, 5, 2,15,13,10,14, 3, 6, 7, 1, 9, 4},
    '{ 7, 9, 3, 1,13,12,11,14, 2, 6, 5,10, 4, 0,15, 8},
    '{ 9, 0, 5, 7, 2, 4,10,15,14, 1,11,12, 6, 8, 3,13},
    '{ 2,12, 6,10, 0,11, 8, 3, 4,13, 7, 5,15,14, 1, 9},
    '{12, 5, 1,15,14,13, 4,10, 0, 7, 6, 3, 9, 2, 8,11},
    '{13,11, 7,14,12, 1, 3, 9, 5, 0,15, 4, 8, 6, 2,10},
    '{ 6,15,14, 9,11, 3, 0, 8,12, 2,13, 7, 1, 4,10, 5},
    '{10, 2, 8, 4, 7, 6, 1, 5,15,11, 9,14, 3,12,13, 0}};

  logic [63:0] msg [16];

  // Word touched by operand k (0=a..3=d) of step s: columns are straight, diagonals rotate by k.
  function automatic int widx(input int s, input int k);
    if (s < 4) return 4 * k + s;
    return 4 * k + ((s - 4 + k) % 4);
  endfunction

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [1023:0] model_v(input int d);
    logic [1023:0] r;
    for (int k = 0; k < 16; k++) r[1023 - 64 * k -: 64] = mv[d][k];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input int d, input exp_t e);
    check($sformatf("dut%0d counter_idx", d), 64'(counter_idx[d]), 64'(e.idx));
    check($sformatf("dut%0d busy", d), 64'(busy[d]), 64'(e.busy));
    check($sformatf("dut%0d done", d), 64'(done[d]), 64'(e.done));
    for (int k = 0; k < 16; k++)
      check($sformatf("dut%0d v%0d", d, k), v_out[d][1023 - 64 * k -: 64], e.v[1023 - 64 * k -: 64]);
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge it describes.
  always begin
    @(posedge clk);
    #1;
    if (q0.size() > 0) compare(0, q0.pop_front());
    if (q1.size() > 0) compare(1, q1.pop_front());
  end

  // Drive one cycle on DUT d (the other DUT sees idle inputs), advance the model, queue the result.
  task automatic drive(input int d, input bit iv, input logic [1023:0] vi, input bit ab,
                       input bit gv, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [63:0] dd);
    exp_t e;
    bit   fin;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      init_valid[j] = 1'b0; abort[j] = 1'b0; g_valid[j] = 1'b0;
    end
    init_valid[d] = iv; v_init[d] = vi; abort[d] = ab; g_valid[d] = gv;
    a_in[d] = a; b_in[d] = b; c_in[d] = c; d_in[d] = dd;
    fin = 1'b0;
    if (mmode[d] != 1) begin
      if (iv) begin
        for (int k = 0; k < 16; k++) mv[d][k] = vi[1023 - 64 * k -: 64];
        mcnt[d] = 0;
        mmode[d] = 1;
      end
    end else if (ab) begin
      mmode[d] = 0;
      mcnt[d] = 0;
    end else if (gv) begin
      mv[d][widx(mcnt[d] % 8, 0)] = a;
      mv[d][widx(mcnt[d] % 8, 1)] = b;
      mv[d][widx(mcnt[d] % 8, 2)] = c;
      mv[d][widx(mcnt[d] % 8, 3)] = dd;
      if (mcnt[d] == last_step[d]) begin
        fin = 1'b1; mmode[d] = 2; mcnt[d] = 0;
      end else begin
        mcnt[d]++;
      end
    end
    e.v = model_v(d);
    e.idx = 7'(mcnt[d]);
    e.busy = (mmode[d] == 1);
    e.done = fin;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [1023:0] rnd_state();
    logic [1023:0] r;
    for (int k = 0; k < 32; k++) r[32 * k +: 32] = $urandom;
    return r;
  endfunction

  task automatic rnd_step(input int d);
    drive(d, 1'b0, '0, 1'b0, 1'b1, rnd64(), rnd64(), rnd64(), rnd64());
  endtask

  // The BLAKE-512 G function for the model's current step, evaluated on the model's own state.
  task automatic blake_g(input int d, output logic [63:0] a, output logic [63:0] b,
                         output logic [63:0] c, output logic [63:0] dd);
    int r, s, x, y;
    r = (mcnt[d] / 8) % 10;
    s = mcnt[d] % 8;
    x = SIGMA[r][2 * s];
    y = SIGMA[r][2 * s + 1];
    a = mv[d][widx(s, 0)]; b = mv[d][widx(s, 1)]; c = mv[d][widx(s, 2)]; dd = mv[d][widx(s, 3)];
    a = a + b + (msg[x] ^ CST[y]);
    dd = rotr(dd ^ a, 32);
    c = c + dd;
    b = rotr(b ^ c, 25);
    a = a + b + (msg[y] ^ CST[x]);
    dd = rotr(dd ^ a, 16);
    c = c + dd;
    b = rotr(b ^ c, 11);
  endtask

  task automatic model_reset();
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k < 16; k++) mv[j][k] = '0;
      mcnt[j] = 0;
      mmode[j] = 0;
    end
  endtask

  task automatic check_reset_now(input string tag);
    for (int j = 0; j < 2; j++) begin
      check($sformatf("%s dut%0d v_out", tag, j), 64'(|v_out[j]), 64'd0);
      check($sformatf("%s dut%0d counter_idx", tag, j), 64'(counter_idx[j]), 64'd0);
      check($sformatf("%s dut%0d busy", tag, j), 64'(busy[j]), 64'd0);
      check($sformatf("%s dut%0d done", tag, j), 64'(done[j]), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] vi;
    logic [63:0] ga, gb, gc, gd;

    rst = 1'b1;
    for (int j = 0; j < 2; j++) begin
      init_valid[j] = 1'b0; abort[j] = 1'b0; g_valid[j] = 1'b0; v_init[j] = '0;
      a_in[j] = '0; b_in[j] = '0; c_in[j] = '0; d_in[j] = '0;
    end
    for (int k = 0; k < 16; k++) msg[k] = '0;
    msg[0] = 64'h6162638000000000;
    msg[13] = 64'd1;
    msg[15] = 64'h18;
    model_reset();
    #1;
    check_reset_now("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load v_k = k, then one directed write per step: step s writes 0xAs/0xBs/0xCs/0xDs.
    for (int k = 0; k < 16; k++) vi[1023 - 64 * k -: 64] = 64'(k);
    drive(0, 1'b1, vi, 1'b0, 1'b1, 64'hFF, 64'hFF, 64'hFF, 64'hFF);
    for (int s = 0; s < 8; s++)
      drive(0, 1'b0, '0, 1'b0, 1'b1, 64'hA0 + 64'(s), 64'hB0 + 64'(s), 64'hC0 + 64'(s), 64'hD0 + 64'(s));

    // Random traffic with gaps and ignored reloads until step 37, then asynchronous reset.
    while (mcnt[0] != 37) begin
      case ($urandom_range(0, 5))
        0: idle(0);
        1: drive(0, 1'b1, rnd_state(), 1'b0, 1'b0, '0, '0, '0, '0);
        default: rnd_step(0);
      endcase
    end
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_now("async reset");
    @(negedge clk);
    rst = 1'b0;

    // Abort together with g_valid at step 10, then g_valid and abort while idle.
    drive(0, 1'b1, rnd_state(), 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (10) rnd_step(0);
    drive(0, 1'b0, '0, 1'b1, 1'b1, rnd64(), rnd64(), rnd64(), rnd64());
    rnd_step(0);
    drive(0, 1'b0, '0, 1'b1, 1'b0, '0, '0, '0, '0);

    // Full 16-round compression of the "abc" block, back-to-back G results.
    for (int k = 0; k < 8; k++) vi[1023 - 64 * k -: 64] = IV[k];
    for (int k = 8; k < 16; k++) vi[1023 - 64 * k -: 64] = CST[k - 8];
    vi[1023 - 64 * 12 -: 64] = CST[4] ^ 64'h18;
    vi[1023 - 64 * 13 -: 64] = CST[5] ^ 64'h18;
    drive(0, 1'b1, vi, 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (128) begin
      blake_g(0, ga, gb, gc, gd);
      drive(0, 1'b0, '0, 1'b0, 1'b1, ga, gb, gc, gd);
    end
    idle(0);
    rnd_step(0);
    idle(0);

    // NUM_ROUNDS=1 instance: eight steps to done, then behaviour in DONE.
    drive(1, 1'b1, rnd_state(), 1'b0, 1'b0, '0, '0, '0, '0);
    repeat (8) rnd_step(1);
    rnd_step(1);
    drive(1, 1'b0, '0, 1'b1, 1'b0, '0, '0, '0, '0);
    drive(1, 1'b1, rnd_state(), 1'b0, 1'b1, rnd64(), rnd64(), rnd64(), rnd64());
    repeat (3) rnd_step(1);
    drive(1, 1'b1, rnd_state(), 1'b0, 1'b1, rnd64(), rnd64(), rnd64(), rnd64());
    idle(1);

    @(posedge clk);
    #3;
    check("scoreboard drained", 64'(q0.size() + q1.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
